// File: rtl/voice_pkg.sv
// Shared types and constants for the voice scheduler and the 3-voice generator.
// Sample/mix widths, scheduler states, waveform selects and config helpers.
package voice_pkg;

  localparam int NUM_VOICES = 3;
  localparam int WAVE_W     = 10;
  localparam int MIX_W      = 12;

  localparam logic [3:0] WAVE_TRI   = 4'b0001;
  localparam logic [3:0] WAVE_SAW   = 4'b0010;
  localparam logic [3:0] WAVE_PULSE = 4'b0100;
  localparam logic [3:0] WAVE_NOISE = 4'b1000;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} sched_state_e;

  typedef struct packed {
    logic [15:0] freq;
    logic [11:0] pw;
    logic [3:0]  wave;
    logic        sync;
    logic        ring;
  } voice_cfg_t;

  // Slice one voice's configuration out of the packed {v2,v1,v0} buses.
  function automatic voice_cfg_t cfg_of(input logic [47:0] freq, input logic [35:0] pw,
                                        input logic [11:0] wave, input logic [2:0] sync,
                                        input logic [2:0] ring, input logic [1:0] v);
    voice_cfg_t c;
    case (v)
      2'd1:    c = '{freq[31:16], pw[23:12], wave[7:4], sync[1], ring[1]};
      2'd2:    c = '{freq[47:32], pw[35:24], wave[11:8], sync[2], ring[2]};
      default: c = '{freq[15:0], pw[11:0], wave[3:0], sync[0], ring[0]};
    endcase
    return c;
  endfunction

  function automatic logic signed [MIX_W-1:0] sext(input logic signed [WAVE_W-1:0] w);
    return {{(MIX_W-WAVE_W){w[WAVE_W-1]}}, w};
  endfunction

endpackage

// File: rtl/voice_scheduler.sv
// Frame sequencer: snapshots per-voice config on each tick, runs voices 0..2 through
// the shared generator and emits their signed sum. Optional VOICE_SCHED_MUTE_EN adds mute_i.
module voice_scheduler
  import voice_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          sample_tick_i,
`ifdef VOICE_SCHED_MUTE_EN
  input  logic [NUM_VOICES-1:0]         mute_i,
`endif
  input  logic [16*NUM_VOICES-1:0]      voice_freq_i,
  input  logic [12*NUM_VOICES-1:0]      voice_pw_i,
  input  logic [4*NUM_VOICES-1:0]       voice_wave_i,
  input  logic [NUM_VOICES-1:0]         voice_sync_i,
  input  logic [NUM_VOICES-1:0]         voice_ring_i,
  output logic                          mv_start_o,
  output logic [1:0]                    mv_voice_o,
  output logic [15:0]                   mv_freq_o,
  output logic [11:0]                   mv_pw_o,
  output logic [3:0]                    mv_wave_sel_o,
  output logic                          mv_sync_o,
  output logic                          mv_ring_o,
  input  logic                          mv_ready_i,
  input  logic signed [WAVE_W-1:0]      mv_wave_i,
  output logic signed [MIX_W-1:0]       mix_o,
  output logic                          mix_valid_o,
  output logic                          busy_o,
  output logic                          overrun_o
);

  sched_state_e                 state;
  logic [1:0]                   idx;
  logic signed [MIX_W-1:0]      acc;
  logic signed [MIX_W-1:0]      sample_ext;
  logic signed [MIX_W-1:0]      acc_next;
  logic [16*NUM_VOICES-1:0]     snap_freq;
  logic [12*NUM_VOICES-1:0]     snap_pw;
  logic [4*NUM_VOICES-1:0]      snap_wave;
  logic [NUM_VOICES-1:0]        snap_sync;
  logic [NUM_VOICES-1:0]        snap_ring;
  voice_cfg_t                   cfg_q;
`ifdef VOICE_SCHED_MUTE_EN
  logic [NUM_VOICES-1:0]        snap_mute;
`endif

  always_comb begin
    sample_ext = sext(mv_wave_i);
`ifdef VOICE_SCHED_MUTE_EN
    // Muted voices still run through the generator so their state keeps advancing.
    if (snap_mute[idx]) sample_ext = '0;
`endif
    acc_next = acc + sample_ext;
  end

  assign busy_o        = (state != IDLE);
  assign overrun_o     = sample_tick_i && (state != IDLE);
  assign mv_voice_o    = idx;
  assign mv_freq_o     = cfg_q.freq;
  assign mv_pw_o       = cfg_q.pw;
  assign mv_wave_sel_o = cfg_q.wave;
  assign mv_sync_o     = cfg_q.sync;
  assign mv_ring_o     = cfg_q.ring;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      mix_o       <= '0;
      mix_valid_o <= 1'b0;
      mv_start_o  <= 1'b0;
      cfg_q       <= '0;
      snap_freq   <= '0;
      snap_pw     <= '0;
      snap_wave   <= '0;
      snap_sync   <= '0;
      snap_ring   <= '0;
`ifdef VOICE_SCHED_MUTE_EN
      snap_mute   <= '0;
`endif
    end else begin
      mv_start_o  <= 1'b0;
      mix_valid_o <= 1'b0;
      case (state)
        IDLE: if (sample_tick_i) begin
          snap_freq  <= voice_freq_i;
          snap_pw    <= voice_pw_i;
          snap_wave  <= voice_wave_i;
          snap_sync  <= voice_sync_i;
          snap_ring  <= voice_ring_i;
`ifdef VOICE_SCHED_MUTE_EN
          snap_mute  <= mute_i;
`endif
          acc        <= '0;
          idx        <= 2'd0;
          // Snapshot is loading this same edge, so voice 0 config comes straight from inputs.
          cfg_q      <= cfg_of(voice_freq_i, voice_pw_i, voice_wave_i,
                               voice_sync_i, voice_ring_i, 2'd0);
          mv_start_o <= 1'b1;
          state      <= START;
        end
        START: state <= WAIT;
        WAIT: if (mv_ready_i) begin
          acc <= acc_next;
          if (idx < 2'(NUM_VOICES-1)) begin
            idx        <= idx + 2'd1;
            cfg_q      <= cfg_of(snap_freq, snap_pw, snap_wave, snap_sync, snap_ring,
                                 idx + 2'd1);
            mv_start_o <= 1'b1;
            state      <= START;
          end else begin
            // Mix is published on entry to DONE so valid coincides with the DONE cycle.
            mix_o       <= acc_next;
            mix_valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a generator model answering 3 cycles after start.
// Build with +define+VOICE_SCHED_MUTE_EN to also exercise the mute path.
module tb_voice_scheduler;
  import voice_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               tick;
  logic [47:0]        vfreq;
  logic [35:0]        vpw;
  logic [11:0]        vwave;
  logic [2:0]         vsync;
  logic [2:0]         vring;
  logic               mv_start;
  logic [1:0]         mv_voice;
  logic [15:0]        mv_freq;
  logic [11:0]        mv_pw;
  logic [3:0]         mv_wave_sel;
  logic               mv_sync;
  logic               mv_ring;
  logic               mv_ready;
  logic signed [9:0]  mv_wave;
  logic signed [11:0] mix;
  logic               mix_valid;
  logic               busy;
  logic               overrun;
`ifdef VOICE_SCHED_MUTE_EN
  logic [2:0]         mute;
`endif

  int vectors = 0;
  int miscompares = 0;
  int samp [3];

  logic        start_log   [20];
  logic        valid_log   [20];
  logic        busy_log    [20];
  logic        overrun_log [20];
  logic [1:0]  voice_log   [20];
  logic [15:0] freq_log    [20];
  int          mix_log     [20];

  voice_scheduler dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .sample_tick_i (tick),
`ifdef VOICE_SCHED_MUTE_EN
    .mute_i        (mute),
`endif
    .voice_freq_i  (vfreq),
    .voice_pw_i    (vpw),
    .voice_wave_i  (vwave),
    .voice_sync_i  (vsync),
    .voice_ring_i  (vring),
    .mv_start_o    (mv_start),
    .mv_voice_o    (mv_voice),
    .mv_freq_o     (mv_freq),
    .mv_pw_o       (mv_pw),
    .mv_wave_sel_o (mv_wave_sel),
    .mv_sync_o     (mv_sync),
    .mv_ring_o     (mv_ring),
    .mv_ready_i    (mv_ready),
    .mv_wave_i     (mv_wave),
    .mix_o         (mix),
    .mix_valid_o   (mix_valid),
    .busy_o        (busy),
    .overrun_o     (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Generator model: ready pulse with samp[voice] three cycles after each start.
  initial begin
    int cnt;
    int v;
    cnt = 0;
    v = 0;
    mv_ready = 1'b0;
    mv_wave = '0;
    forever begin
      @(negedge clk);
      mv_ready = 1'b0;
      if (!rst_n) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mv_ready = 1'b1;
            mv_wave = samp[v][9:0];
          end
        end
        if (mv_start) begin
          cnt = 3;
          v = int'(mv_voice);
        end
      end
    end
  end

  task automatic capture(input int k);
    start_log[k]   = mv_start;
    valid_log[k]   = mix_valid;
    busy_log[k]    = busy;
    overrun_log[k] = overrun;
    voice_log[k]   = mv_voice;
    freq_log[k]    = mv_freq;
    mix_log[k]     = int'(mix);
  endtask

  // Tick in cycle T (k=0); optional second tick at k=tick2; voice 1 freq changed at k=chg.
  task automatic do_frame(input int tick2, input int chg);
    @(negedge clk);
    tick = 1'b1;
    #1 capture(0);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      tick = (k == tick2);
      if (k == chg) vfreq[31:16] = 16'hFFFF;
      #1 capture(k);
    end
    tick = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({mv_start, mix_valid, busy, overrun} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0000", {mv_start, mix_valid, busy, overrun});
    end
    vectors++;
    if (mix !== 12'sd0 || mv_voice !== 2'd0 || mv_freq !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data got mix=%0d voice=%0d freq=%h want 0", mix, mv_voice, mv_freq);
    end
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int starts;
    int valids;
    samp[0] = 100; samp[1] = -200; samp[2] = 511;
    do_frame(-1, -1);
    starts = 0; valids = 0;
    for (int k = 0; k < 20; k++) begin
      starts += int'(start_log[k]);
      valids += int'(valid_log[k]);
    end
    vectors++;
    if (!(start_log[1] && start_log[5] && start_log[9]) || starts != 3) begin
      miscompares++;
      $display("FAIL basic_starts got %0d starts (T+1/5/9=%b%b%b) want 3 at T+1/5/9",
               starts, start_log[1], start_log[5], start_log[9]);
    end
    vectors++;
    if (voice_log[1] !== 2'd0 || voice_log[5] !== 2'd1 || voice_log[9] !== 2'd2) begin
      miscompares++;
      $display("FAIL basic_voice got %0d/%0d/%0d want 0/1/2", voice_log[1], voice_log[5], voice_log[9]);
    end
    vectors++;
    if (valid_log[13] !== 1'b1 || valids != 1) begin
      miscompares++;
      $display("FAIL basic_valid got T+13=%b count=%0d want 1/1", valid_log[13], valids);
    end
    vectors++;
    if (mix_log[13] != 411) begin
      miscompares++;
      $display("FAIL basic_mix got %0d want 411", mix_log[13]);
    end
    vectors++;
    if (busy_log[13] !== 1'b1 || busy_log[14] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle got busy T+13=%b T+14=%b want 1/0", busy_log[13], busy_log[14]);
    end
  endtask

  task automatic test_extremes;
    samp[0] = -512; samp[1] = -512; samp[2] = -512;
    do_frame(-1, -1);
    vectors++;
    if (mix_log[13] != -1536) begin
      miscompares++;
      $display("FAIL min_mix got %0d want -1536", mix_log[13]);
    end
    samp[0] = 511; samp[1] = 511; samp[2] = 511;
    do_frame(-1, -1);
    vectors++;
    if (mix_log[13] != 1533) begin
      miscompares++;
      $display("FAIL max_mix got %0d want 1533", mix_log[13]);
    end
    vectors++;
    if (mix !== 12'sd1533) begin
      miscompares++;
      $display("FAIL mix_hold got %0d want 1533", mix);
    end
  endtask

  task automatic test_overrun;
    int ovr;
    int valids;
    int busys;
    samp[0] = 100; samp[1] = -200; samp[2] = 511;
    do_frame(6, -1);
    ovr = 0; valids = 0; busys = 0;
    for (int k = 0; k < 20; k++) begin
      ovr    += int'(overrun_log[k]);
      valids += int'(valid_log[k]);
      if (k >= 1 && k <= 13) busys += int'(busy_log[k]);
    end
    vectors++;
    if (overrun_log[6] !== 1'b1 || ovr != 1) begin
      miscompares++;
      $display("FAIL overrun_pulse got T+6=%b count=%0d want 1/1", overrun_log[6], ovr);
    end
    vectors++;
    if (valids != 1 || mix_log[13] != 411) begin
      miscompares++;
      $display("FAIL overrun_frame got valids=%0d mix=%0d want 1/411", valids, mix_log[13]);
    end
    vectors++;
    if (busys != 13 || busy_log[0] !== 1'b0 || busy_log[14] !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_busy got %0d busy cycles want 13 (T+1..T+13)", busys);
    end
  endtask

  task automatic test_snapshot;
    vfreq = {16'h5678, 16'h1234, 16'h0001};
    vpw   = {12'h333, 12'h222, 12'h111};
    vwave = {WAVE_NOISE, WAVE_PULSE, WAVE_SAW};
    vsync = 3'b100;
    vring = 3'b011;
    do_frame(-1, 3);
    vectors++;
    if (freq_log[1] !== 16'h0001 || freq_log[5] !== 16'h1234 || freq_log[8] !== 16'h1234) begin
      miscompares++;
      $display("FAIL snap_freq got %h/%h/%h want 0001/1234/1234", freq_log[1], freq_log[5], freq_log[8]);
    end
    vectors++;
    if (freq_log[9] !== 16'h5678) begin
      miscompares++;
      $display("FAIL snap_freq_v2 got %h want 5678", freq_log[9]);
    end
    // Voice 2 configuration is still on the bus after the frame.
    vectors++;
    if ({mv_sync, mv_ring} !== 2'b10 || mv_wave_sel !== WAVE_NOISE || mv_pw !== 12'h333) begin
      miscompares++;
      $display("FAIL v2_cfg got sync=%b ring=%b wave=%b pw=%h want 1/0/1000/333",
               mv_sync, mv_ring, mv_wave_sel, mv_pw);
    end
  endtask

  task automatic test_reset_mid_frame;
    int valids;
    valids = 0;
    @(negedge clk);
    tick = 1'b1;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      tick = 1'b0;
      if (k == 7) begin
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mix !== 12'sd0 || busy !== 1'b0 || mv_freq !== 16'h0 || mv_voice !== 2'd0) begin
          miscompares++;
          $display("FAIL async_reset got mix=%0d busy=%b freq=%h voice=%0d want 0",
                   mix, busy, mv_freq, mv_voice);
        end
      end
      if (k == 9) rst_n = 1'b1;
      #1 valids += int'(mix_valid);
    end
    vectors++;
    if (valids != 0) begin
      miscompares++;
      $display("FAIL abort_valid got %0d want 0", valids);
    end
    samp[0] = 100; samp[1] = -200; samp[2] = 511;
    do_frame(-1, -1);
    vectors++;
    if (valid_log[13] !== 1'b1 || mix_log[13] != 411) begin
      miscompares++;
      $display("FAIL post_reset got valid=%b mix=%0d want 1/411", valid_log[13], mix_log[13]);
    end
  endtask

`ifdef VOICE_SCHED_MUTE_EN
  task automatic test_mute;
    int starts;
    mute = 3'b010;
    samp[0] = 100; samp[1] = -200; samp[2] = 511;
    do_frame(-1, -1);
    starts = 0;
    for (int k = 0; k < 20; k++) starts += int'(start_log[k]);
    vectors++;
    if (starts != 3 || mix_log[13] != 611) begin
      miscompares++;
      $display("FAIL mute got starts=%0d mix=%0d want 3/611", starts, mix_log[13]);
    end
    mute = 3'b000;
  endtask
`endif

  initial begin
    tick  = 1'b0;
    vfreq = {16'h0300, 16'h0200, 16'h0100};
    vpw   = {12'h800, 12'h800, 12'h800};
    vwave = {WAVE_TRI, WAVE_SAW, WAVE_PULSE};
    vsync = 3'b000;
    vring = 3'b000;
    samp[0] = 0; samp[1] = 0; samp[2] = 0;
`ifdef VOICE_SCHED_MUTE_EN
    mute = 3'b000;
`endif
    test_reset;
    test_basic;
    test_extremes;
    test_overrun;
    test_snapshot;
    test_reset_mid_frame;
`ifdef VOICE_SCHED_MUTE_EN
    test_mute;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
